// File: rtl/dmux8_dispatch_ctrl_pkg.sv
// Shared constants and types for the 8-bit 1-to-4 dispatch controller.
// Holds mode, channel and FSM state encodings plus a popcount helper.
package dmux8_dispatch_ctrl_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  localparam logic [1:0] CH_W = 2'd0;
  localparam logic [1:0] CH_X = 2'd1;
  localparam logic [1:0] CH_Y = 2'd2;
  localparam logic [1:0] CH_Z = 2'd3;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  function automatic logic [2:0] pop4(
    input logic [3:0] v
  );
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/dmux8_dispatch_ctrl_demux.sv
// 8-bit 1-to-4 demultiplexer: steers d onto the output chosen by sel.
// Ports: sel (2b select), d (8b data), y_w/y_x/y_y/y_z (8b, zero unless selected).
module dmux8_dispatch_ctrl_demux
  import dmux8_dispatch_ctrl_pkg::*;
(
  input  logic [1:0] sel,
  input  logic [7:0] d,
  output logic [7:0] y_w,
  output logic [7:0] y_x,
  output logic [7:0] y_y,
  output logic [7:0] y_z
);

  always_comb begin
    y_w = 8'h00;
    y_x = 8'h00;
    y_y = 8'h00;
    y_z = 8'h00;
    unique case (1'b1)
      (sel == CH_W): y_w = d;
      (sel == CH_X): y_x = d;
      (sel == CH_Y): y_y = d;
      (sel == CH_Z): y_z = d;
      default: ;
    endcase
  end

endmodule

// File: rtl/dmux8_dispatch_ctrl.sv
// Dispatch controller: steers an input byte stream into four one-entry
// channel registers (W,X,Y,Z) by tag or round-robin, with safe mode switch.
// Ports: clk, rst (sync high); cfg_wr/cfg_mode/cfg_busy/mode (config);
//   in_data/in_dest/in_valid/in_ready (input stream);
//   out_w..out_z/out_valid/out_ready (channels); rr_ptr, deliv_cnt (status).
module dmux8_dispatch_ctrl
  import dmux8_dispatch_ctrl_pkg::*;
#(
  parameter logic RESET_MODE = 1'b0,
  parameter int   CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic             cfg_mode,
  output logic             cfg_busy,
  output logic             mode,
  input  logic [7:0]       in_data,
  input  logic [1:0]       in_dest,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_w,
  output logic [7:0]       out_x,
  output logic [7:0]       out_y,
  output logic [7:0]       out_z,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [1:0]       rr_ptr,
  output logic [CNT_W-1:0] deliv_cnt
);

  state_e state_q, state_d;
  logic mode_q, mode_d;
  logic pend_q, pend_d;
  logic busy_q, busy_d;
  logic [1:0] rr_q, rr_d;
  logic [3:0][7:0] data_q, data_d;
  logic [3:0] vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] sel;
  logic [3:0][7:0] dmx;
  logic [3:0] load;
  logic [3:0] drain;
  logic accept;

  assign sel = (mode_q == MODE_RR) ? rr_q : in_dest;

  assign in_ready = !busy_q
                  && (!vld_q[sel] || out_ready[sel]);

  // A config write in the same cycle takes priority
  // over an otherwise acceptable byte.
  assign accept = in_valid && in_ready && !cfg_wr;

  assign load  = accept ? (4'b0001 << sel) : 4'b0000;
  assign drain = vld_q & out_ready;

  dmux8_dispatch_ctrl_demux u_demux (
    .sel (sel),
    .d   (in_data),
    .y_w (dmx[0]),
    .y_x (dmx[1]),
    .y_y (dmx[2]),
    .y_z (dmx[3])
  );

  always_comb begin
    data_d = data_q;
    for (int i = 0; i < 4; i++) begin
      if (load[i]) begin
        data_d[i] = dmx[i];
      end
    end
  end

  // Reload wins over drain, so a channel can
  // sustain one byte per cycle.
  assign vld_d = (vld_q & ~drain) | load;

  assign cnt_d = cnt_q + CNT_W'(pop4(drain));

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pend_d  = pend_q;
    busy_d  = busy_q;
    rr_d    = rr_q;
    unique case (state_q)
      ST_RUN: begin
        if (cfg_wr) begin
          pend_d  = cfg_mode;
          busy_d  = 1'b1;
          state_d = ST_DRAIN;
        end else if (accept && mode_q == MODE_RR) begin
          rr_d = rr_q + 2'd1;
        end
      end
      ST_DRAIN: begin
        if (cfg_wr) begin
          pend_d = cfg_mode;
        end
        if (vld_q == 4'b0000) begin
          mode_d  = pend_d;
          rr_d    = 2'd0;
          busy_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      mode_q  <= RESET_MODE;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      rr_q    <= 2'd0;
      data_q  <= '0;
      vld_q   <= 4'b0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cfg_busy  = busy_q;
  assign mode      = mode_q;
  assign rr_ptr    = rr_q;
  assign out_w     = data_q[0];
  assign out_x     = data_q[1];
  assign out_y     = data_q[2];
  assign out_z     = data_q[3];
  assign out_valid = vld_q;
  assign deliv_cnt = cnt_q;

endmodule

// File: tb/tb_dmux8_dispatch_ctrl.sv
// Self-checking bench for dmux8_dispatch_ctrl.
// Scoreboard queues per channel, filled on accept, drained on handshake.
module tb_dmux8_dispatch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_wr;
  logic       cfg_mode;
  logic       cfg_busy;
  logic       mode;
  logic [7:0] in_data;
  logic [1:0] in_dest;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_w, out_x, out_y, out_z;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [1:0] rr_ptr;
  logic [7:0] deliv_cnt;

  int total = 0;
  int bad   = 0;
  int drv_ch = 0;
  int exp_cnt = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] q3[$];

  always #5 clk = ~clk;

  dmux8_dispatch_ctrl #(
    .RESET_MODE (1'b0),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_wr    (cfg_wr),
    .cfg_mode  (cfg_mode),
    .cfg_busy  (cfg_busy),
    .mode      (mode),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_w     (out_w),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_z     (out_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr),
    .deliv_cnt (deliv_cnt)
  );

  function automatic logic [7:0] ch_data(int i);
    case (i)
      0: return out_w;
      1: return out_x;
      2: return out_y;
      default: return out_z;
    endcase
  endfunction

  task automatic sb_push(int ch, logic [7:0] d);
    case (ch)
      0: q0.push_back(d);
      1: q1.push_back(d);
      2: q2.push_back(d);
      default: q3.push_back(d);
    endcase
  endtask

  task automatic sb_pop_check(int ch);
    logic [7:0] e;
    logic [7:0] a;
    int n;
    case (ch)
      0: n = q0.size();
      1: n = q1.size();
      2: n = q2.size();
      default: n = q3.size();
    endcase
    a = ch_data(ch);
    total++;
    if (n == 0) begin
      bad++;
      $display("FAIL sb_ch%0d: unexpected delivery %h, required none",
               ch, a);
    end else begin
      case (ch)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        2: e = q2.pop_front();
        default: e = q3.pop_front();
      endcase
      if (a !== e) begin
        bad++;
        $display("FAIL sb_ch%0d: got %h required %h", ch, a, e);
      end
    end
  endtask

  // Inputs change 1 time unit after posedge, so values seen
  // here are those the DUT samples at the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      q2.delete();
      q3.delete();
      exp_cnt = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          exp_cnt++;
          sb_pop_check(i);
        end
      end
      if (in_valid && in_ready && !cfg_wr) begin
        sb_push(drv_ch, in_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_wr = 1'b0;
    cfg_mode = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_dest = 2'd0;
    out_ready = 4'h0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_mode", 32'(mode), 32'h0);
    chk("rst_rr", 32'(rr_ptr), 32'h0);
    chk("rst_busy", 32'(cfg_busy), 32'h0);
    chk("rst_cnt", 32'(deliv_cnt), 32'h0);
    chk("rst_data", {out_w, out_x, out_y, out_z}, 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
  endtask

  task automatic test_direct();
    do_reset();
    in_dest = 2'd2;
    drv_ch = 2;
    in_data = 8'hA5;
    in_valid = 1'b1;
    chk("dir_ready0", 32'(in_ready), 32'h1);
    step();
    chk("dir_outy", 32'(out_y), 32'hA5);
    chk("dir_valid", 32'(out_valid), 32'h4);
    in_data = 8'h5A;
    chk("dir_stall", 32'(in_ready), 32'h0);
    step();
    chk("dir_hold", 32'(out_y), 32'hA5);
    out_ready = 4'b0100;
    #1;
    chk("dir_unstall", 32'(in_ready), 32'h1);
    step();
    chk("dir_reload", 32'(out_y), 32'h5A);
    chk("dir_valid2", 32'(out_valid), 32'h4);
    in_valid = 1'b0;
    step();
    chk("dir_empty", 32'(out_valid), 32'h0);
    chk("dir_keep", 32'(out_y), 32'h5A);
    out_ready = 4'h0;
  endtask

  task automatic test_throughput();
    do_reset();
    in_dest = 2'd0;
    drv_ch = 0;
    out_ready = 4'b0001;
    in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_data = 8'(k);
      chk("thr_ready", 32'(in_ready), 32'h1);
      step();
      chk("thr_outw", 32'(out_w), 32'(k));
    end
    in_valid = 1'b0;
    step();
    chk("thr_cnt", 32'(deliv_cnt), 32'd8);
    out_ready = 4'h0;
  endtask

  task automatic test_round_robin();
    int rr_seq[6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    cfg_wr = 1'b1;
    cfg_mode = 1'b1;
    step();
    cfg_wr = 1'b0;
    chk("rr_busy", 32'(cfg_busy), 32'h1);
    step();
    chk("rr_idle", 32'(cfg_busy), 32'h0);
    chk("rr_mode", 32'(mode), 32'h1);
    out_ready = 4'hF;
    in_valid = 1'b1;
    in_dest = 2'd3;
    for (int k = 0; k < 5; k++) begin
      in_data = 8'h10 + 8'(k);
      drv_ch = rr_seq[k];
      chk("rr_ptr", 32'(rr_ptr), 32'(rr_seq[k]));
      step();
      chk("rr_data", 32'(ch_data(rr_seq[k])), 32'(in_data));
    end
    chk("rr_ptr_end", 32'(rr_ptr), 32'(rr_seq[5]));
    in_valid = 1'b0;
    step();
    out_ready = 4'h0;
  endtask

  task automatic test_mode_switch();
    do_reset();
    in_valid = 1'b1;
    in_dest = 2'd0;
    drv_ch = 0;
    in_data = 8'hC1;
    step();
    in_dest = 2'd3;
    drv_ch = 3;
    in_data = 8'hC2;
    step();
    chk("ms_full", 32'(out_valid), 32'h9);
    in_dest = 2'd1;
    drv_ch = 1;
    in_data = 8'hC3;
    cfg_wr = 1'b1;
    cfg_mode = 1'b1;
    step();
    cfg_wr = 1'b0;
    chk("ms_nox", 32'(out_valid), 32'h9);
    chk("ms_busy", 32'(cfg_busy), 32'h1);
    chk("ms_rdy0", 32'(in_ready), 32'h0);
    chk("ms_oldmode", 32'(mode), 32'h0);
    step();
    chk("ms_busy2", 32'(cfg_busy), 32'h1);
    in_valid = 1'b0;
    out_ready = 4'hF;
    step();
    chk("ms_drained", 32'(out_valid), 32'h0);
    chk("ms_busy3", 32'(cfg_busy), 32'h1);
    step();
    chk("ms_done", 32'(cfg_busy), 32'h0);
    chk("ms_mode", 32'(mode), 32'h1);
    chk("ms_rr", 32'(rr_ptr), 32'h0);
    out_ready = 4'h0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_dest = 2'd1;
    drv_ch = 1;
    out_ready = 4'b0010;
    in_valid = 1'b1;
    in_data = 8'hB1;
    step();
    chk("b2b_v1", 32'(out_valid[1]), 32'h1);
    chk("b2b_d1", 32'(out_x), 32'hB1);
    in_data = 8'hB2;
    step();
    chk("b2b_v2", 32'(out_valid[1]), 32'h1);
    chk("b2b_d2", 32'(out_x), 32'hB2);
    in_valid = 1'b0;
    step();
    chk("b2b_empty", 32'(out_valid), 32'h0);
    chk("b2b_cnt", 32'(deliv_cnt), 32'd2);
    out_ready = 4'h0;
  endtask

  task automatic test_wrap();
    do_reset();
    in_dest = 2'd0;
    drv_ch = 0;
    out_ready = 4'b0001;
    in_valid = 1'b1;
    for (int k = 0; k < 256; k++) begin
      in_data = 8'(k);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("wrap_cnt", 32'(deliv_cnt), 32'h0);
    chk("wrap_model", 32'(exp_cnt), 32'd256);
    out_ready = 4'h0;
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    in_valid = 1'b1;
    in_dest = 2'd1;
    drv_ch = 1;
    in_data = 8'hD1;
    step();
    in_dest = 2'd3;
    drv_ch = 3;
    in_data = 8'hD3;
    step();
    in_valid = 1'b0;
    cfg_wr = 1'b1;
    cfg_mode = 1'b1;
    step();
    cfg_wr = 1'b0;
    chk("rmd_busy", 32'(cfg_busy), 32'h1);
    chk("rmd_valid", 32'(out_valid), 32'hA);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmd_valid0", 32'(out_valid), 32'h0);
    chk("rmd_data0", {out_w, out_x, out_y, out_z}, 32'h0);
    chk("rmd_busy0", 32'(cfg_busy), 32'h0);
    chk("rmd_mode0", 32'(mode), 32'h0);
    chk("rmd_ready", 32'(in_ready), 32'h1);
  endtask

  initial begin
    rst = 1'b1;
    cfg_wr = 1'b0;
    cfg_mode = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_dest = 2'd0;
    out_ready = 4'h0;
    step();
    test_reset();
    test_direct();
    test_throughput();
    test_round_robin();
    test_mode_switch();
    test_back_to_back();
    test_wrap();
    test_reset_mid_drain();
    out_ready = 4'hF;
    step();
    step();
    chk("sb_empty",
        32'(q0.size() + q1.size() + q2.size() + q3.size()),
        32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmux8_dispatch_ctrl.md
Name: dmux8_dispatch_ctrl

Overview:
- Sequencing controller for the 8-bit 1-to-4 demultiplexer datapath.
- Accepts a byte stream on a valid/ready input and steers each byte to one of four output channels W, X, Y, Z.
- Steering is either by explicit destination tag (DIRECT) or by rotating pointer (ROUND_ROBIN).
- Each channel has a one-entry holding register with its own valid/ready handshake. A quiescent-switch protocol makes mode changes safe.

Parameters:
- RESET_MODE, 0, mode loaded at reset (0 = DIRECT, 1 = ROUND_ROBIN).
- CNT_W, 8, width of the delivered-byte counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- cfg_wr  input  1  one-cycle request to change the steering mode.
- cfg_mode  input  1  requested mode, sampled when cfg_wr=1.
- cfg_busy  output  1  a mode change is pending.
- mode  output  1  current active mode.
- in_data  input  8  byte to dispatch.
- in_dest  input  2  destination tag: 0=W, 1=X, 2=Y, 3=Z. Used in DIRECT mode only.
- in_valid  input  1  input byte valid.
- in_ready  output  1  controller can accept a byte this cycle.
- out_w, out_x, out_y, out_z  output  8 each  channel holding registers.
- out_valid  output  4  per-channel valid; bit0=W … bit3=Z.
- out_ready  input  4  per-channel consumer ready.
- rr_ptr  output  2  next round-robin target.
- deliv_cnt  output  CNT_W  total output handshakes completed.

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - out_w..out_z=0, out_valid=0, mode=RESET_MODE, rr_ptr=0.
  - cfg_busy=0, deliv_cnt=0, pending mode register=0.
  - Any held bytes are discarded.
- Target channel sel: in_dest when mode=DIRECT, rr_ptr when mode=ROUND_ROBIN.
- in_ready = !cfg_busy && (!out_valid[sel] || out_ready[sel]).
  - Combinational.
  - Must not depend on in_valid.
- Input accept (in_valid && in_ready at an edge):
  - out_<sel> <= in_data; out_valid[sel] <= 1.
  - Byte is visible one cycle after accept; no combinational path from in_data to the outputs.
  - Routing goes through the demux sub-module: sel drives its select and in_data its data.
  - Only the selected channel's register loads.
- Output drain (out_valid[i] && out_ready[i] at an edge):
  - out_valid[i] <= 0 unless the same channel is reloaded in that cycle, in which case it stays 1 with the new byte.
  - Sustained throughput is 1 byte/cycle per channel.
  - Data register holds its last value after drain.
- deliv_cnt increments by the number of output handshakes that cycle (0..4) and wraps modulo 2^CNT_W.
- rr_ptr advances by 1 mod 4 on each accept in ROUND_ROBIN mode only (3 -> 0). There is no skipping of full channels: input stalls until the target drains.
- Mode change state machine:
  - RUN: cfg_wr=1 latches cfg_mode into pending and moves to DRAIN (cfg_busy=1).
  - DRAIN: in_ready=0 and no new accepts; outputs keep draining. A further cfg_wr overwrites pending. When out_valid==0 at an edge: mode <= pending, rr_ptr <= 0, move to RUN (cfg_busy=0).
  - Minimum DRAIN length is one cycle, even if already empty.
  - cfg_wr together with an in_valid that would otherwise be accepted: the cfg_wr wins, and the byte is not accepted.
- Reset mid-operation (any state) returns to RUN with the reset values above.

Decomposition:
- Shared package/include holds:
  - mode constants MODE_DIRECT=0 and MODE_RR=1.
  - channel index constants CH_W=0..CH_Z=3.
  - FSM state encodings ST_RUN and ST_DRAIN.
- The existing 8-bit 1-to-4 demux library module is the natural sub-module, instantiated once for data steering. Control, holding registers and the FSM stay in this block.

Test Plan:
- Reset with DIRECT mode: in_dest=2, in_data=8'hA5, in_valid=1, out_ready=0 -> next cycle out_y=8'hA5, out_valid=4'b0100. A second byte to dest 2 -> in_ready=0 until out_ready[2]=1.
- Throughput: dest=0, out_ready[0]=1, bytes 8'h01..8'h08 on consecutive cycles -> in_ready held 1, out_w follows with 1-cycle lag, deliv_cnt=8.
- ROUND_ROBIN: mode=1, out_ready=4'hF, bytes 8'h10,8'h11,8'h12,8'h13,8'h14 -> arrive at W,X,Y,Z,W; rr_ptr sequence 0,1,2,3,0,1.
- Mode switch while full: W and Z held with out_ready=0, cfg_wr=1, cfg_mode=1 -> cfg_busy=1, in_ready=0. Release out_ready -> cfg_busy falls the edge after out_valid=0, mode=1, rr_ptr=0.
- Simultaneous drain and reload on X with a 2-byte burst -> out_valid[1] never drops and out_x updates each cycle. Counter wrap: CNT_W=8 after 256 deliveries -> deliv_cnt=0.
- Reset mid-DRAIN with out_valid=4'b1010 -> next cycle all outputs at reset values and in_ready=1.
